// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, response decode and FSM states for the memory arbiter
package mem_pkg;

    localparam logic [2:0] PROT_INSTR = 3'b101;
    localparam logic [2:0] PROT_DATA  = 3'b001;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    function automatic logic is_err(input logic [1:0] resp);
        return resp == RESP_SLVERR || resp == RESP_DECERR;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: AXI4-lite master port bundle between the arbiter and the memory fabric
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; req[0] is fetch, req[1] is data
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last;

    // on a tie the side that did not win last time gets the grant
    always_comb begin
        gnt[1] = req[1] & (~req[0] | ~last);
        gnt[0] = req[0] & ~gnt[1];
    end

    // remember the most recent winner, starting from fetch
    always_ff @(posedge clk) begin
        if (!reset)
            last <= 1'b0;
        else if (accept)
            last <= gnt[1];
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI4-lite master between fetch and load/store requesters
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_resp_valid,
    output logic [DATA_W-1:0]   i_resp_data,
    output logic                i_resp_err,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_write,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_resp_data,
    output logic                d_resp_err,
    mem_arbiter_if.master       axi
);

    state_t              state, state_n;
    logic                aw_done, w_done, aw_done_n, w_done_n;
    logic [1:0]          gnt;
    logic                accept, done;
    logic [1:0]          resp;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          prot_q;
    logic [DATA_W-1:0]   wdata_q, data_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                id_q, write_q;
    logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                i_resp_q, d_resp_q, err_q;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({d_req_valid, i_req_valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    assign i_req_ready = reset && state == IDLE && gnt[0];
    assign d_req_ready = reset && state == IDLE && gnt[1];
    assign accept      = i_req_ready || d_req_ready;
    assign done        = (state == RD_DATA && axi.rvalid) || (state == WR_RESP && axi.bvalid);
    assign resp        = write_q ? axi.bresp : axi.rresp;

    // next state and write-handshake tracking; AW and W retire independently
    always_comb begin
        state_n   = state;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        case (state)
            IDLE: begin
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
                if (accept)
                    state_n = (gnt[1] && d_req_write) ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: if (axi.arready) state_n = RD_DATA;
            RD_DATA: if (axi.rvalid) state_n = IDLE;
            WR_REQ: begin
                aw_done_n = aw_done | axi.awready;
                w_done_n  = w_done | axi.wready;
                if (aw_done_n && w_done_n)
                    state_n = WR_RESP;
            end
            WR_RESP: if (axi.bvalid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end

    // registered AXI controls, captured request and one-cycle response
    always_ff @(posedge clk) begin
        if (!reset) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            i_resp_q  <= 1'b0;
            d_resp_q  <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            prot_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            id_q      <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            arvalid_q <= state_n == RD_ADDR;
            rready_q  <= state_n == RD_DATA;
            awvalid_q <= state_n == WR_REQ && !aw_done_n;
            wvalid_q  <= state_n == WR_REQ && !w_done_n;
            bready_q  <= state_n == WR_RESP;
            i_resp_q  <= done && !id_q;
            d_resp_q  <= done && id_q;
            if (accept) begin
                addr_q  <= gnt[1] ? d_req_addr : i_req_addr;
                prot_q  <= gnt[1] ? PROT_DATA : PROT_INSTR;
                wdata_q <= d_req_wdata;
                wstrb_q <= d_req_wstrb;
                id_q    <= gnt[1];
                write_q <= gnt[1] && d_req_write;
            end
            if (done) begin
                err_q  <= is_err(resp);
                data_q <= (write_q || is_err(resp)) ? '0 : axi.rdata;
            end
        end
    end

    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = prot_q;
    assign axi.rready  = rready_q;
    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awprot  = prot_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = bready_q;

    assign i_resp_valid = i_resp_q;
    assign i_resp_data  = data_q;
    assign i_resp_err   = err_q;
    assign d_resp_valid = d_resp_q;
    assign d_resp_data  = data_q;
    assign d_resp_err   = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single AXI4-lite master port between the instruction-fetch requester and the data load/store requester. It accepts one request at a time through a simple valid/ready request interface and arbitrates round-robin when both sides are pending. It then runs the AXI read (AR/R) or write (AW/W/B) handshake and returns a single-cycle response to the winner. It sits between the core's fetch/execute logic and the memory fabric.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- i_req_valid / i_req_ready  in / out  1  fetch request handshake
- i_req_addr  in  ADDR_W  fetch address
- i_resp_valid  out  1  one-cycle fetch response strobe
- i_resp_data  out  DATA_W  fetched word
- i_resp_err  out  1  fetch bus error
- d_req_valid / d_req_ready  in / out  1  data request handshake
- d_req_write  in  1  1 = store, 0 = load
- d_req_addr, d_req_wdata  in  ADDR_W, DATA_W  data address and store data
- d_req_wstrb  in  DATA_W/8  store byte strobes
- d_resp_valid, d_resp_data, d_resp_err  out  1, DATA_W, 1  data response
- awvalid/awready, awaddr, awprot  out/in, out, out  1, ADDR_W, 3  AXI write address
- wvalid/wready, wdata, wstrb  out/in, out, out  1, DATA_W, DATA_W/8  AXI write data
- bvalid/bready, bresp  in/out, in  1, 2  AXI write response
- arvalid/arready, araddr, arprot  out/in, out, out  1, ADDR_W, 3  AXI read address
- rvalid/rready, rdata, rresp  in/out, in, in  1, DATA_W, 2  AXI read data

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - Grant is combinational from the two valids and the `last` pointer.
  - Only one of i_req_ready/d_req_ready is high: the one for the granted requester, and only when that requester's valid is high.
  - When both requesters are pending, the one not in `last` wins.
  - `last` resets to fetch, so data wins the first tie after reset.
- On accept:
  - Address, wdata, wstrb, requester id and write flag are captured into registers. `last` is updated.
  - A fetch or a load goes to RD_ADDR. A store goes to WR_REQ.
  - Fetch drives arprot 3'b101 (privileged, instruction). Data drives arprot and awprot 3'b001 (privileged, data).
- RD_ADDR: arvalid is high. Move to RD_DATA on arready.
- RD_DATA: rready is high. On rvalid, return to IDLE and register the response.
- WR_REQ:
  - awvalid and wvalid are both high.
  - Each one drops independently after its own handshake; flags aw_done and w_done track this.
  - Move to WR_RESP when both handshakes are done. Simultaneous acceptance in one cycle counts as both.
- WR_RESP: bready is high. On bvalid, return to IDLE and register the response.
- Response:
  - The granted requester's resp_valid pulses for exactly one cycle.
  - err = 1 for SLVERR (2'b10) or DECERR (2'b11); OKAY and EXOKAY are success.
  - resp_data = rdata on successful reads. It is 0 on error and on writes.
- AXI outputs are driven from registers and stay stable while their valid is high.

## Timing
- Reset (reset=0 at an edge):
  - All valid/ready/resp outputs go to 0, all address/data outputs to 0, prot outputs to 0.
  - State returns to IDLE and `last` to fetch.
  - A reset in mid-transaction abandons that transaction with no response.
- Minimum read latency:
  - Accept at edge N.
  - arvalid high in cycle N+1; arready seen in N+1.
  - rready high in N+2; rvalid seen in N+2.
  - resp_valid high in N+3.
- Minimum write latency:
  - Accept at N.
  - AW and W accepted in N+1.
  - bready in N+2.
  - resp_valid in N+3.
- resp_valid coincides with IDLE. A new request can be accepted in that same cycle, giving back-to-back throughput of one transaction per 3 cycles.
- One outstanding transaction at a time. No request is accepted outside IDLE.

## Structure
- Package mem_pkg holds:
  - PROT_INSTR = 3'b101 and PROT_DATA = 3'b001
  - RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR
  - the state enum
- Sub-module rr_arbiter2 is a two-input round-robin grant with a `last` register and an update-on-accept input. It is instantiated once.

## Test plan
- Fetch-only read of 0x100, slave returns 0xDEADBEEF with arready/rvalid immediate -> araddr=0x100, arprot=101, i_resp_valid in N+3 with data 0xDEADBEEF, err=0.
- Both requesters valid continuously, fetch 0x0, load 0x40 -> grants alternate data, fetch, data, and so on; neither requester waits more than one transaction.
- Store 0x11223344, wstrb 4'b0011, to 0x80, with wready arriving 3 cycles before awready -> wvalid drops after its handshake, awvalid held until its handshake, bready only after both, d_resp_valid once.
- Load with rresp=2'b11 -> d_resp_err=1, d_resp_data=0; the next fetch completes normally.
- Slave stalls arready for 5 cycles -> arvalid, araddr and arprot remain stable; no request is accepted meanwhile.
- Reset asserted in RD_DATA -> all outputs 0 at the next edge, no resp_valid; after release a tie goes to data.
